// File: rtl/pe_operand_loader.sv
// rtl/pe_operand_loader.sv - Sequential operand loader/settle/capture front end for the combinational FP PE
// Optional feature macro: PE_LOADER_NAN_FLAG_EN (adds out_nan, captured alongside out_result).
module pe_operand_loader #(
  parameter int N      = 2,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            abort,
  output logic [N*32-1:0] pe_a,
  output logic [N*32-1:0] pe_b,
  input  logic [31:0]     pe_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
`ifdef PE_LOADER_NAN_FLAG_EN
  output logic            out_nan,
`endif
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_OUT} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      cnt_q;
  logic [N*32-1:0] pe_a_q;
  logic [N*32-1:0] pe_b_q;
  logic [31:0]     out_result_q;
  logic            out_valid_q;

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_LOAD);
  assign pe_a       = pe_a_q;
  assign pe_b       = pe_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

`ifdef PE_LOADER_NAN_FLAG_EN
  logic nan_in_q;
  logic out_nan_q;
  assign out_nan = out_nan_q;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      idx_q        <= '0;
      cnt_q        <= '0;
      pe_a_q       <= '0;
      pe_b_q       <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
`ifdef PE_LOADER_NAN_FLAG_EN
      nan_in_q     <= 1'b0;
      out_nan_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          // abort outranks a simultaneous handshake: the offered pair is dropped
          if (abort) begin
            idx_q <= '0;
`ifdef PE_LOADER_NAN_FLAG_EN
            nan_in_q <= 1'b0;
`endif
          end else if (in_valid) begin
            pe_a_q[32*idx_q +: 32] <= in_a;
            pe_b_q[32*idx_q +: 32] <= in_b;
`ifdef PE_LOADER_NAN_FLAG_EN
            if (idx_q == '0) nan_in_q <= is_nan(in_a) | is_nan(in_b);
            else             nan_in_q <= nan_in_q | is_nan(in_a) | is_nan(in_b);
`endif
            if (idx_q == IW'(N-1)) begin
              idx_q   <= '0;
              cnt_q   <= 8'(SETTLE-1);
              state_q <= S_WAIT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            idx_q   <= '0;
            state_q <= S_LOAD;
`ifdef PE_LOADER_NAN_FLAG_EN
            nan_in_q <= 1'b0;
`endif
          end else if (cnt_q == 8'd0) begin
            out_result_q <= pe_result;
            out_valid_q  <= 1'b1;
            state_q      <= S_OUT;
`ifdef PE_LOADER_NAN_FLAG_EN
            out_nan_q    <= is_nan(pe_result) | nan_in_q;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_OUT: begin
          // pending result must drain; abort has no effect here
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule
